acc_alu_out: RTL
================

Name: acc_alu_out

Overview:
Downstream datapath stage consuming the control word from the SAP-style control unit (LA, EA, SU, EU, LB, LO). Holds accumulator A and register B, computes A+B or A-B, and drives the W-bus. On OUT instructions it pushes A into a small output FIFO with a valid/ready interface to the display/output consumer. The control unit cannot stall, so the FIFO absorbs a slow consumer.

Parameters:
WIDTH, 8, datapath and W-bus width
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on posedge
clr  in  1  asynchronous active-low reset
wbus_in  in  WIDTH  W-bus value driven by memory/IR
LA  in  1  load accumulator
EA  in  1  enable accumulator onto W-bus
SU  in  1  1=subtract, 0=add
EU  in  1  enable adder/subtractor result onto W-bus
LB  in  1  load B register
LO  in  1  load output (push A to FIFO)
wbus_out  out  WIDTH  block's W-bus contribution
wbus_oe  out  1  high when EA|EU
out_data  out  WIDTH  FIFO head
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head
out_ovf  out  1  sticky: push dropped while full
carry  out  1  carry flag
zero  out  1  zero flag

Behaviour:
- Reset (clr=0, async, any time incl. mid-instruction): A=0, B=0, carry=0, zero=0, FIFO empty, out_valid=0, out_ovf=0, LO edge register=0. wbus_out/wbus_oe stay combinational from A and inputs, so wbus_out=0 unless EU with nonzero result.
- Arithmetic: sum[WIDTH:0] = A + (SU ? ~B : B) + SU. result = sum[WIDTH-1:0]. cout = sum[WIDTH]. For subtract, cout=1 means no borrow.
- Bus: wbus_out = EA ? A : (EU ? result : 0). EA wins if EA&EU. wbus_oe = EA|EU.
- A load on LA: source = EU ? result (internal path, no bus round-trip) : wbus_in. LA&EA with EU=0 reloads wbus_in.
- B load on LB: B <= wbus_in. SU has no effect on B.
- LA and LB in the same cycle: both load. A's source is evaluated with the old B.
- Flags (see Optional Feature): on LA&EU, carry<=cout and zero<=(result==0). On LA without EU, zero<=(wbus_in==0) and carry is held.
- LO is level-held for several control states. Push happens only on the rising edge: LO=1 and lo_q=0, where lo_q is LO registered. Pushed value is current A, or the new A value if LA is active in the same cycle.
- FIFO: data visible on out_data with out_valid=1 one cycle after push. Pop when out_valid&out_ready.
  - Push while full with no pop: data dropped, out_ovf<=1 until reset.
  - Push and pop together when full: both occur, no overflow.
  - Pop while empty: ignored.
  - Pointers wrap modulo OUT_DEPTH. Count width is clog2(OUT_DEPTH)+1.

Optional Feature:
ACC_ALU_FLAGS_EN.
- Defined: carry/zero registers behave as above.
- Undefined: no flag registers are built, and carry and zero are tied 0.

Decomposition:
- Shared package sap_pkg: WIDTH default, opcode constants (LDA=4'b0000, ADD=4'b0001, SUB=4'b0010, OUT=4'b1110, HLT=4'b1111), control-word bit indices.
- Sub-module sap_out_fifo (WIDTH, OUT_DEPTH): push/pop/full/empty/overflow.
- Adder, registers, and bus mux stay in acc_alu_out.

Test Plan:
1. Reset mid-op: A=0x55, FIFO holding 2 entries, pull clr low between clock edges -> A=0, out_valid=0, out_ovf=0, flags 0 immediately, without waiting for a clock edge.
2. LDA/ADD: LA with wbus_in=0x05; then LB with wbus_in=0x03; then LA+EU, SU=0 -> wbus_out=0x08 while EU; A=0x08, carry=0, zero=0.
3. SUB to zero: A=0x03, B=0x03, LA+EU+SU -> A=0x00, zero=1, carry=1. Then A=0x02, B=0x03 -> A=0xFF, carry=0.
4. ADD overflow: A=0xF0, B=0x20, LA+EU -> A=0x10, carry=1, zero=0. Build without ACC_ALU_FLAGS_EN -> carry=zero=0.
5. OUT held 3 cycles: LO=EA=1 for 3 clocks, A=0x10, out_ready=0 -> exactly one entry; out_data=0x10 one cycle after the first edge. Set out_ready=1 -> one beat, then out_valid=0.
6. Overflow: out_ready=0, 4 separate LO pulses (0x01..0x04), 5th pulse -> dropped, out_ovf=1, drain yields 01,02,03,04. Refill to full, then push with out_ready=1 -> accepted, count stays 4, no new overflow.

Source files
------------

// File: rtl/sap_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sap_pkg
//  Description : Shared SAP-style constants: default datapath width, opcode
//                values, control-word bit positions and a control-word
//                decoder used by the datapath stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package sap_pkg;

    // Default datapath / W-bus width
    localparam int C_SAP_WIDTH = 8;

    // Instruction opcodes (upper nibble of the instruction register)
    localparam logic [3:0] C_OP_LDA = 4'b0000;
    localparam logic [3:0] C_OP_ADD = 4'b0001;
    localparam logic [3:0] C_OP_SUB = 4'b0010;
    localparam logic [3:0] C_OP_OUT = 4'b1110;
    localparam logic [3:0] C_OP_HLT = 4'b1111;

    // Bit positions of this stage's signals inside the control word
    localparam int C_CW_LA   = 5;
    localparam int C_CW_EA   = 4;
    localparam int C_CW_SU   = 3;
    localparam int C_CW_EU   = 2;
    localparam int C_CW_LB   = 1;
    localparam int C_CW_LO   = 0;
    localparam int C_CW_BITS = 6;

    // Decoded control signals consumed by the accumulator/ALU/output stage
    typedef struct packed {
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    // Split a raw control word into named fields
    function automatic ctrl_t cw_unpack(input logic [C_CW_BITS-1:0] cw);
        ctrl_t c;
        c.la = cw[C_CW_LA];
        c.ea = cw[C_CW_EA];
        c.su = cw[C_CW_SU];
        c.eu = cw[C_CW_EU];
        c.lb = cw[C_CW_LB];
        c.lo = cw[C_CW_LO];
        return c;
    endfunction

endpackage : sap_pkg
`default_nettype wire

// File: rtl/sap_out_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sap_out_fifo
//  Description : Small output FIFO between the datapath and a slow display
//                consumer. Pushes can never be stalled, so a push into a
//                full FIFO without a simultaneous pop is dropped and a sticky
//                overflow flag is raised until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sap_out_fifo #(
    parameter int WIDTH     = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             ovf_o
);

    localparam int C_PTR_W = $clog2(OUT_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    logic [WIDTH-1:0]   mem_q [OUT_DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_q;
    logic [C_PTR_W-1:0] rd_ptr_q;
    logic [C_CNT_W-1:0] count_q;
    logic [C_CNT_W-1:0] count_d;
    logic               ovf_q;
    logic               ovf_d;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == C_CNT_W'(OUT_DEPTH));
    // Pops on an empty FIFO are ignored; a pop frees the slot for a same-cycle push
    assign w_pop   = pop_i & ~w_empty;
    assign w_push  = push_i & (~w_full | w_pop);

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = ~w_empty;
    assign ovf_o   = ovf_q;

    // Occupancy and sticky overflow next-state
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - C_CNT_W'(1);
        end
        if (push_i && !w_push) begin
            ovf_d = 1'b1;
        end
    end

    // Pointer, occupancy and overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + C_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + C_PTR_W'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : sap_out_fifo
`default_nettype wire

// File: rtl/acc_alu_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : acc_alu_out
//  Description : Accumulator A, register B, adder/subtractor and W-bus driver
//                of a SAP-style CPU, plus an output FIFO fed on OUT.
//                Optional carry/zero flag registers are built only when the
//                macro ACC_ALU_FLAGS_EN is defined; otherwise both flags are 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_alu_out
    import sap_pkg::*;
#(
    parameter int WIDTH     = C_SAP_WIDTH,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] wbus_in,
    input  logic             LA,
    input  logic             EA,
    input  logic             SU,
    input  logic             EU,
    input  logic             LB,
    input  logic             LO,
    output logic [WIDTH-1:0] wbus_out,
    output logic             wbus_oe,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ovf,
    output logic             carry,
    output logic             zero
);

    ctrl_t            w_ctrl;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic             lo_q;
    logic [WIDTH-1:0] w_b_operand;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_cout;
    logic             w_push;

    assign w_ctrl = cw_unpack({LA, EA, SU, EU, LB, LO});

    // Two's-complement add/subtract: subtract is A + ~B + 1
    always_comb begin
        w_b_operand = w_ctrl.su ? ~b_q : b_q;
        w_sum       = {1'b0, a_q} + {1'b0, w_b_operand} + {{WIDTH{1'b0}}, w_ctrl.su};
    end

    assign w_result = w_sum[WIDTH-1:0];
    assign w_cout   = w_sum[WIDTH];

    // Bus contribution: accumulator has priority over the ALU result
    always_comb begin
        wbus_out = '0;
        if (w_ctrl.ea) begin
            wbus_out = a_q;
        end else if (w_ctrl.eu) begin
            wbus_out = w_result;
        end
    end

    assign wbus_oe = w_ctrl.ea | w_ctrl.eu;

    // Register next-state; the ALU result feeds A directly, avoiding the bus
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (w_ctrl.la) begin
            a_d = w_ctrl.eu ? w_result : wbus_in;
        end
        if (w_ctrl.lb) begin
            b_d = wbus_in;
        end
    end

    // A, B and LO history registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_q  <= '0;
            b_q  <= '0;
            lo_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            lo_q <= w_ctrl.lo;
        end
    end

    // LO is held across several control states; only its rising edge pushes,
    // and the pushed value already includes a same-cycle accumulator load.
    assign w_push = w_ctrl.lo & ~lo_q;

    sap_out_fifo #(
        .WIDTH     (WIDTH),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk         (clk),
        .rst_n       (clr),
        .push_i      (w_push),
        .push_data_i (a_d),
        .pop_i       (out_ready),
        .data_o      (out_data),
        .valid_o     (out_valid),
        .ovf_o       (out_ovf)
    );

`ifdef ACC_ALU_FLAGS_EN
    logic carry_q;
    logic carry_d;
    logic zero_q;
    logic zero_d;

    // Flags update only on accumulator loads; a bus load leaves carry alone
    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (w_ctrl.la) begin
            if (w_ctrl.eu) begin
                carry_d = w_cout;
                zero_d  = (w_result == '0);
            end else begin
                zero_d  = (wbus_in == '0);
            end
        end
    end

    // Flag registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign carry = carry_q;
    assign zero  = zero_q;
`else
    logic w_unused_cout;
    assign w_unused_cout = w_cout;
    assign carry         = 1'b0;
    assign zero          = 1'b0;
`endif

endmodule : acc_alu_out
`default_nettype wire
